// File: rtl/arf_sched.sv
// Two-stage fixed-point combiner. One shared multiplier runs N_TAP MAC products and then four mixing products.
// Define ARF_SCHED_SAT_EN to saturate every product reduction and every addition; otherwise they wrap.
module arf_sched #(
  parameter int W     = 16,
  parameter int N_TAP = 8,
  parameter int FRAC  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_TAP*W-1:0]     in_x,
  input  logic [(N_TAP+4)*W-1:0] in_c,
  input  logic [2*W-1:0]         in_s,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_0,
  output logic [W-1:0]           out_1,
  output logic                   busy
);

  localparam int IW = (N_TAP > 2) ? $clog2(N_TAP) : 1;
  localparam int CW = (IW < 2) ? 2 : IW;

  typedef enum logic [1:0] {IDLE, MAC, FIN, OUTS} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [W-1:0]   x_q [N_TAP];
  logic signed [W-1:0]   c_q [N_TAP];
  logic signed [W-1:0]   cf_q [4];
  logic signed [W-1:0]   s0_q, s1_q;
  logic signed [W-1:0]   y0_q, y1_q, acc0_q, acc1_q, out0_q, out1_q;
  logic signed [W-1:0]   op_a, op_b, prod_w;
  logic signed [2*W-1:0] prod_full;

`ifdef ARF_SCHED_SAT_EN
  localparam logic signed [W-1:0]   MAX_W = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]   MIN_W = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [2*W-1:0] MAX_L = (2*W)'(MAX_W);
  localparam logic signed [2*W-1:0] MIN_L = (2*W)'(MIN_W);
`endif

  function automatic logic signed [W-1:0] reduce_p(input logic signed [2*W-1:0] v);
`ifdef ARF_SCHED_SAT_EN
    if (v > MAX_L) return MAX_W;
    if (v < MIN_L) return MIN_W;
`endif
    return W'(v);
  endfunction

  function automatic logic signed [W-1:0] add_w(input logic signed [W-1:0] a,
                                                input logic signed [W-1:0] b);
`ifdef ARF_SCHED_SAT_EN
    logic signed [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1]) return s[W] ? MIN_W : MAX_W;
    return s[W-1:0];
`else
    return a + b;
`endif
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = (state_q == OUTS);
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = MAC;
        cnt_d   = '0;
      end
      MAC: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N_TAP - 1)) begin
          state_d = FIN;
          cnt_d   = '0;
        end
      end
      FIN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q[1:0] == 2'd3) state_d = OUTS;
      end
      OUTS: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      for (int k = 0; k < N_TAP; k++) begin
        x_q[k] <= in_x[k*W +: W];
        c_q[k] <= in_c[k*W +: W];
      end
      for (int k = 0; k < 4; k++) cf_q[k] <= in_c[(N_TAP+k)*W +: W];
      s0_q <= in_s[W-1:0];
      s1_q <= in_s[2*W-1:W];
    end
  end

  // Shared multiplier: taps during MAC, then ca/cb/cc/cd against y0/y1 during FIN.
  always_comb begin
    op_a = cf_q[cnt_q[1:0]];
    op_b = cnt_q[0] ? y1_q : y0_q;
    if (state_q == MAC) begin
      op_a = c_q[cnt_q[IW-1:0]];
      op_b = x_q[cnt_q[IW-1:0]];
    end
    prod_full = (2*W)'(op_a) * (2*W)'(op_b);
    prod_w    = reduce_p(prod_full >>> FRAC);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y0_q   <= '0;
      y1_q   <= '0;
      acc0_q <= '0;
      acc1_q <= '0;
      out0_q <= '0;
      out1_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          y0_q <= '0;
          y1_q <= '0;
        end
        MAC: begin
          if (cnt_q < CW'(N_TAP / 2)) y0_q <= add_w(y0_q, prod_w);
          else                         y1_q <= add_w(y1_q, prod_w);
        end
        FIN: begin
          case (cnt_q[1:0])
            2'd0: acc0_q <= prod_w;
            2'd1: acc0_q <= add_w(add_w(acc0_q, prod_w), s0_q);
            2'd2: acc1_q <= prod_w;
            default: begin
              out0_q <= acc0_q;
              out1_q <= add_w(add_w(acc1_q, prod_w), s1_q);
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign out_0 = out0_q;
  assign out_1 = out1_q;

endmodule

// File: tb/tb_arf_sched.sv
// Directed bench for arf_sched: a frame-level reference model checked every cycle, plus literal expectations.
module tb_arf_sched;
  localparam int W = 16;
  localparam int N = 8;
  localparam int F = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [N*W-1:0]       in_x = '0;
  logic [(N+4)*W-1:0]   in_c = '0;
  logic [2*W-1:0]       in_s = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [W-1:0]         out_0, out_1;
  logic                 busy;

  arf_sched #(.W(W), .N_TAP(N), .FRAC(F)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_c(in_c), .in_s(in_s), .out_valid(out_valid),
    .out_ready(out_ready), .out_0(out_0), .out_1(out_1), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic longint red(input longint v);
`ifdef ARF_SCHED_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    longint m = v & 64'hFFFF;
    if (m >= 32768) m -= 65536;
    return m;
`endif
  endfunction

  function automatic longint sx(input logic [15:0] v);
    longint r = longint'(v);
    if (r >= 32768) r -= 65536;
    return r;
  endfunction

  function automatic longint mulp(input longint a, input longint b);
    return red((a * b) >>> F);
  endfunction

  task automatic model_frame(output logic [15:0] o0, output logic [15:0] o1);
    longint y0 = 0, y1 = 0, p;
    longint ca, cb, cc, cd;
    for (int k = 0; k < N; k++) begin
      p = mulp(sx(in_x[k*W +: W]), sx(in_c[k*W +: W]));
      if (k < N/2) y0 = red(y0 + p);
      else         y1 = red(y1 + p);
    end
    ca = sx(in_c[(N+0)*W +: W]);
    cb = sx(in_c[(N+1)*W +: W]);
    cc = sx(in_c[(N+2)*W +: W]);
    cd = sx(in_c[(N+3)*W +: W]);
    o0 = 16'(red(red(mulp(ca, y0) + mulp(cb, y1)) + sx(in_s[15:0])));
    o1 = 16'(red(red(mulp(cc, y0) + mulp(cd, y1)) + sx(in_s[31:16])));
  endtask

  // Frame-level model: accept when idle, result appears N+5 cycles later, leave on out_ready.
  bit          m_idle = 1'b1, m_out = 1'b0, cmp_en = 1'b0;
  int          m_t = 0;
  logic [15:0] e0 = '0, e1 = '0, sh0 = '0, sh1 = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_idle = 1'b1; m_out = 1'b0; sh0 = '0; sh1 = '0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_idle = 1'b0; m_t = 1;
        model_frame(e0, e1);
      end
    end else if (m_out) begin
      if (out_ready) begin m_out = 1'b0; m_idle = 1'b1; end
    end else begin
      m_t++;
      if (m_t == N + 5) begin m_out = 1'b1; sh0 = e0; sh1 = e1; end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_in_ready", in_ready, m_idle);
      chk("cyc_busy", busy, !m_idle);
      chk("cyc_out_valid", out_valid, m_out);
      chk("cyc_out_0", out_0, sh0);
      chk("cyc_out_1", out_1, sh1);
    end
  end

  logic [15:0] xa [N];
  logic [15:0] cva [N+4];
  logic [15:0] s0v, s1v;

  task automatic set_all(input logic [15:0] xv, input logic [15:0] cv);
    for (int k = 0; k < N; k++) xa[k] = xv;
    for (int k = 0; k < N+4; k++) cva[k] = cv;
    s0v = '0; s1v = '0;
  endtask

  task automatic drive_frame();
    for (int k = 0; k < N; k++) in_x[k*W +: W] = xa[k];
    for (int k = 0; k < N+4; k++) in_c[k*W +: W] = cva[k];
    in_s = {s1v, s0v};
  endtask

  task automatic send(output int acc_e);
    int n = 0;
    drive_frame();
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("send_timeout", 0, 1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_e = cyc;
  endtask

  task automatic wait_out(input int acc_e, output logic [15:0] o0, output logic [15:0] o1,
                          output int lat);
    int n = 0;
    lat = -1; o0 = 'x; o1 = 'x;
    while (n < 40) begin
      @(negedge clk);
      if (out_valid) begin
        lat = cyc - acc_e + 1; o0 = out_0; o1 = out_1;
        break;
      end
      n++;
    end
    if (lat < 0) chk("out_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int a, lat, quiet;
    logic [15:0] o0, o1;

    rst_n = 1'b0;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_0", out_0, 0);
    chk("rst_out_1", out_1, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame
    set_all(16'h0100, 16'h0100);
    send(a);
    wait_out(a, o0, o1, lat);
    chk("basic_latency", lat, 13);
    chk("basic_out_0", o0, 16'h0800);
    chk("basic_out_1", o1, 16'h0800);

    // State term and negative coefficient
    set_all(16'h0100, 16'h0100);
    s0v = 16'hFF00; cva[N+3] = 16'hFF00;
    send(a);
    wait_out(a, o0, o1, lat);
    chk("neg_out_0", o0, 16'h0700);
    chk("neg_out_1", o1, 16'h0000);

    // Overflow of the first product
    set_all(16'h0000, 16'h0000);
    xa[0] = 16'h4000; cva[0] = 16'h0400; cva[N] = 16'h0100;
    send(a);
    wait_out(a, o0, o1, lat);
`ifdef ARF_SCHED_SAT_EN
    chk("ovf_out_0", o0, 16'h7FFF);
`else
    chk("ovf_out_0", o0, 16'h0000);
`endif
    chk("ovf_out_1", o1, 16'h0000);

    // Backpressure with a competing offer
    set_all(16'h0100, 16'h0100);
    s0v = 16'hFF00; cva[N+3] = 16'hFF00;
    out_ready = 1'b0;
    send(a);
    wait_out(a, o0, o1, lat);
    chk("bp_out_0", o0, 16'h0700);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_x = {N{16'h2222}};
      @(negedge clk);
      chk("bp_hold_out_0", out_0, o0);
      chk("bp_hold_out_1", out_1, o1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_in_ready", in_ready, 1);
    chk("bp_idle_out_valid", out_valid, 0);
    chk("bp_idle_out_0", out_0, 16'h0700);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_not_accepted", busy, 0);
    @(posedge clk); #1;

    // Reset during MAC
    set_all(16'h0100, 16'h0100);
    send(a);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_0", out_0, 0);
    quiet = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) quiet = 0;
    end
    chk("midrst_no_out_valid", quiet, 1);
    @(posedge clk); #1;
    set_all(16'h0100, 16'h0100);
    s0v = 16'hFF00; cva[N+3] = 16'hFF00;
    send(a);
    wait_out(a, o0, o1, lat);
    chk("midrst_next_latency", lat, 13);
    chk("midrst_next_out_0", o0, 16'h0700);
    chk("midrst_next_out_1", o1, 16'h0000);

    // Inputs change during MAC
    set_all(16'h0100, 16'h0100);
    send(a);
    in_x = {N{16'h7ABC}};
    in_c = {(N+4){16'h8123}};
    in_s = 32'h5555_AAAA;
    @(posedge clk); #1;
    in_x = {N{16'hFFFF}};
    wait_out(a, o0, o1, lat);
    chk("holdoff_out_0", o0, 16'h0800);
    chk("holdoff_out_1", o1, 16'h0800);

    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
